// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch timekeeping core.
// Digit fields are plain binary and never exceed the *_MAX values below.
package stopwatch_pkg;

    localparam int CS_W  = 7;
    localparam int SEC_W = 6;
    localparam int MIN_W = 6;

    localparam logic [CS_W-1:0]  CS_MAX  = 7'd99;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        PAUSE = ST_PAUSE
    } state_e;

    typedef struct packed {
        logic [MIN_W-1:0] mins;
        logic [SEC_W-1:0] secs;
        logic [CS_W-1:0]  cs;
    } sw_time_t;

    function automatic logic at_max(sw_time_t t);
        return (t.cs == CS_MAX) && (t.secs == SEC_MAX) && (t.mins == MIN_MAX);
    endfunction

    // Cascaded increment; the terminal value 59:59.99 rolls to zero.
    function automatic sw_time_t advance(sw_time_t t);
        sw_time_t n = t;
        if (t.cs == CS_MAX) begin
            n.cs = '0;
            if (t.secs == SEC_MAX) begin
                n.secs = '0;
                n.mins = (t.mins == MIN_MAX) ? '0 : t.mins + 1'b1;
            end else begin
                n.secs = t.secs + 1'b1;
            end
        end else begin
            n.cs = t.cs + 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Button pulses in, display fields and status out of the stopwatch core.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic             start_stop;
    logic             lap;
    logic             clear;
    logic [CS_W-1:0]  ms_10;
    logic [SEC_W-1:0] secs;
    logic [MIN_W-1:0] mins;
    logic             running;
    logic             lap_active;
    logic             wrap;

    modport master (
        output start_stop, lap, clear,
        input  ms_10, secs, mins, running, lap_active, wrap
    );

    modport slave (
        input  start_stop, lap, clear,
        output ms_10, secs, mins, running, lap_active, wrap
    );

endinterface

// File: rtl/tick_prescaler.sv
// Divides the board clock down to the hundredths tick; holds while en is low.
module tick_prescaler #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: run/pause FSM, cascaded cs/sec/min counters,
// lap snapshot and registered display outputs.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    stopwatch_counter_if.slave  bus
);

    state_e   state_q, state_d;
    sw_time_t count_q, count_d;
    sw_time_t snap_q, snap_d;
    sw_time_t disp_q, disp_d;
    logic     lap_q, lap_d;
    logic     wrap_q, wrap_d;
    logic     tick;

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == RUN),
        .clr   (bus.clear),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        snap_d  = snap_q;
        lap_d   = lap_q;
        wrap_d  = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            count_d = '0;
            lap_d   = 1'b0;
        end else begin
            // The tick is taken from the registered state, so a tick that
            // lands with a RUN->PAUSE press is still counted.
            if (tick) begin
                count_d = advance(count_q);
                wrap_d  = at_max(count_q);
            end
            if (bus.start_stop) begin
                case (state_q)
                    IDLE, PAUSE: state_d = RUN;
                    RUN:         state_d = PAUSE;
                    default:     state_d = IDLE;
                endcase
            end
            if (bus.lap && (state_q != IDLE)) begin
                lap_d = !lap_q;
                if (!lap_q) begin
                    snap_d = count_q;
                end
            end
        end
        disp_d = lap_d ? snap_d : count_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            snap_q  <= '0;
            disp_q  <= '0;
            lap_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            snap_q  <= snap_d;
            disp_q  <= disp_d;
            lap_q   <= lap_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.ms_10      = disp_q.cs;
    assign bus.secs       = disp_q.secs;
    assign bus.mins       = disp_q.mins;
    assign bus.running    = (state_q == RUN);
    assign bus.lap_active = lap_q;
    assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with a 10-clock tick (CLK_HZ=10, TICK_HZ=1).
module tb_stopwatch_counter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [18:0] got;

    stopwatch_counter_if bus();

    stopwatch_counter #(
        .CLK_HZ  (10),
        .TICK_HZ (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] tv(input int m, input int s, input int c);
        logic [5:0] mm;
        logic [5:0] ss;
        logic [6:0] cc;
        mm = 6'(m);
        ss = 6'(s);
        cc = 7'(c);
        return {mm, ss, cc};
    endfunction

    // All tasks start and end on a falling edge; inputs change there.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic ss, input logic lp, input logic clr);
        bus.start_stop = ss;
        bus.lap        = lp;
        bus.clear      = clr;
        @(negedge clk);
        bus.start_stop = 1'b0;
        bus.lap        = 1'b0;
        bus.clear      = 1'b0;
    endtask

    task automatic test_reset();
        cycles(2);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 0)) begin
            errors++; $display("FAIL reset_time got %h want %h", got, tv(0, 0, 0));
        end
        checks++;
        if ({bus.running, bus.lap_active, bus.wrap} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {bus.running, bus.lap_active, bus.wrap});
        end
        rst_n = 1'b1;
        cycles(4);
    endtask

    task automatic test_count();
        pulse(1'b1, 1'b0, 1'b0);
        cycles(999);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 99)) begin
            errors++; $display("FAIL count_999 got %h want %h", got, tv(0, 0, 99));
        end
        cycles(1);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 1, 0)) begin
            errors++; $display("FAIL count_1000 got %h want %h", got, tv(0, 1, 0));
        end
        checks++;
        if ({bus.running, bus.wrap} !== 2'b10) begin
            errors++; $display("FAIL count_flags got %b want 10", {bus.running, bus.wrap});
        end
    endtask

    task automatic test_wrap();
        pulse(1'b0, 1'b0, 1'b1);
        force dut.count_q = tv(59, 59, 98);
        @(negedge clk);
        release dut.count_q;
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(59, 59, 98)) begin
            errors++; $display("FAIL wrap_preload got %h want %h", got, tv(59, 59, 98));
        end
        pulse(1'b1, 1'b0, 1'b0);
        cycles(10);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(59, 59, 99) || bus.wrap !== 1'b0) begin
            errors++; $display("FAIL wrap_last got %h wrap %b want %h wrap 0", got, bus.wrap, tv(59, 59, 99));
        end
        cycles(10);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 0) || bus.wrap !== 1'b1) begin
            errors++; $display("FAIL wrap_roll got %h wrap %b want 0 wrap 1", got, bus.wrap);
        end
        cycles(1);
        checks++;
        if (bus.wrap !== 1'b0) begin
            errors++; $display("FAIL wrap_width got %b want 0", bus.wrap);
        end
        cycles(9);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 1) || bus.running !== 1'b1) begin
            errors++; $display("FAIL wrap_continue got %h run %b want %h run 1", got, bus.running, tv(0, 0, 1));
        end
    endtask

    task automatic test_pause();
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        cycles(250);
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.running !== 1'b0) begin
            errors++; $display("FAIL pause_state got %b want 0", bus.running);
        end
        cycles(50);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 25)) begin
            errors++; $display("FAIL pause_hold got %h want %h", got, tv(0, 0, 25));
        end
        // 251 RUN edges already banked, so the next tick needs 9 more.
        pulse(1'b1, 1'b0, 1'b0);
        cycles(8);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 25)) begin
            errors++; $display("FAIL resume_early got %h want %h", got, tv(0, 0, 25));
        end
        cycles(1);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 26)) begin
            errors++; $display("FAIL resume_tick got %h want %h", got, tv(0, 0, 26));
        end
    endtask

    task automatic test_lap();
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        cycles(400);
        pulse(1'b0, 1'b1, 1'b0);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 40) || bus.lap_active !== 1'b1) begin
            errors++; $display("FAIL lap_capture got %h lap %b want %h lap 1", got, bus.lap_active, tv(0, 0, 40));
        end
        cycles(149);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 40)) begin
            errors++; $display("FAIL lap_frozen got %h want %h", got, tv(0, 0, 40));
        end
        cycles(150);
        pulse(1'b0, 1'b1, 1'b0);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 70) || bus.lap_active !== 1'b0) begin
            errors++; $display("FAIL lap_release got %h lap %b want %h lap 0", got, bus.lap_active, tv(0, 0, 70));
        end
    endtask

    task automatic test_clear_priority();
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        cycles(3170);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 3, 17)) begin
            errors++; $display("FAIL clear_pre got %h want %h", got, tv(0, 3, 17));
        end
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 0) || {bus.running, bus.lap_active} !== 2'b00) begin
            errors++; $display("FAIL clear_same got %h run/lap %b want 0 00", got, {bus.running, bus.lap_active});
        end
        cycles(20);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 0) || bus.running !== 1'b0) begin
            errors++; $display("FAIL clear_idle got %h run %b want 0 run 0", got, bus.running);
        end
    endtask

    task automatic test_async_reset();
        pulse(1'b1, 1'b0, 1'b0);
        cycles(55);
        pulse(1'b0, 1'b1, 1'b0);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 5) || bus.lap_active !== 1'b1) begin
            errors++; $display("FAIL async_pre got %h lap %b want %h lap 1", got, bus.lap_active, tv(0, 0, 5));
        end
        #2 rst_n = 1'b0;
        #1;
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 0) || {bus.running, bus.lap_active, bus.wrap} !== 3'b000) begin
            errors++; $display("FAIL async_reset got %h flags %b want 0 000", got, {bus.running, bus.lap_active, bus.wrap});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.lap_active !== 1'b0) begin
            errors++; $display("FAIL idle_lap got %b want 0", bus.lap_active);
        end
        cycles(20);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 0) || bus.running !== 1'b0) begin
            errors++; $display("FAIL idle_hold got %h run %b want 0 run 0", got, bus.running);
        end
        pulse(1'b1, 1'b0, 1'b0);
        cycles(10);
        got = {bus.mins, bus.secs, bus.ms_10};
        checks++;
        if (got !== tv(0, 0, 1)) begin
            errors++; $display("FAIL post_reset_tick got %h want %h", got, tv(0, 0, 1));
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.start_stop = 1'b0;
        bus.lap        = 1'b0;
        bus.clear      = 1'b0;
        test_reset();
        test_count();
        test_wrap();
        test_pause();
        test_lap();
        test_clear_priority();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
